// File: rtl/mul_share_arbiter_pkg.sv
// Shared types and widths for the shared-multiplier arbiter and its iterative core.
// Holds the state encodings and a two's-complement magnitude helper.
package mul_share_arbiter_pkg;

    localparam int OP_W   = 8;
    localparam int PROD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_RESP = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        CORE_IDLE = 2'd0,
        CORE_LOAD = 2'd1,
        CORE_ACC  = 2'd2,
        CORE_DONE = 2'd3
    } core_state_t;

    // -128 maps to 8'h80, which is the correct unsigned magnitude.
    function automatic logic [OP_W-1:0] magnitude(input logic [OP_W-1:0] v);
        return v[OP_W-1] ? (~v + 8'd1) : v;
    endfunction

endpackage

// File: rtl/mul_share_arbiter_core.sv
// Iterative signed 8x8 multiplier: start latches operands, one |a| add per cycle.
// Latency: start at T -> done pulse at T+2+|b|; product valid during the done cycle.
// No backpressure: the caller must consume product while done is high.
module mul_seq_core
    import mul_share_arbiter_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   a,
    input  logic [OP_W-1:0]   b,
    output logic              done,
    output logic [PROD_W-1:0] product
);

    core_state_t       state_q, state_d;
    logic [OP_W-1:0]   a_raw, b_raw;
    logic [OP_W-1:0]   mag_a, mag_b;
    logic              neg;
    logic [PROD_W-1:0] acc;

    always_comb begin
        state_d = state_q;
        case (state_q)
            CORE_IDLE: if (start) state_d = CORE_LOAD;
            CORE_LOAD: state_d = (magnitude(b_raw) == '0) ? CORE_DONE : CORE_ACC;
            CORE_ACC:  if (mag_b == 8'd1) state_d = CORE_DONE;
            CORE_DONE: state_d = CORE_IDLE;
            default:   state_d = CORE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CORE_IDLE;
            a_raw   <= '0;
            b_raw   <= '0;
            mag_a   <= '0;
            mag_b   <= '0;
            neg     <= 1'b0;
            acc     <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                CORE_IDLE: begin
                    if (start) begin
                        a_raw <= a;
                        b_raw <= b;
                    end
                end
                CORE_LOAD: begin
                    mag_a <= magnitude(a_raw);
                    mag_b <= magnitude(b_raw);
                    neg   <= a_raw[OP_W-1] ^ b_raw[OP_W-1];
                    acc   <= '0;
                end
                CORE_ACC: begin
                    acc   <= acc + {8'd0, mag_a};
                    mag_b <= mag_b - 8'd1;
                end
                default: ;
            endcase
        end
    end

    assign done    = (state_q == CORE_DONE);
    assign product = neg ? (~acc + 16'd1) : acc;

endmodule

// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one iterative signed multiplier among NREQ requesters.
// Latency: accept at T -> rsp_valid from T+3+|b|; one operation in flight at a time.
// Backpressure: response held until rsp_ready of the owner; req_ready low outside IDLE.
module mul_share_arbiter
    import mul_share_arbiter_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                 pclk,
    input  logic                 presetn,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [8*NREQ-1:0]    req_a,
    input  logic [8*NREQ-1:0]    req_b,
    output logic [NREQ-1:0]      req_ready,
    output logic [NREQ-1:0]      rsp_valid,
    input  logic [NREQ-1:0]      rsp_ready,
    output logic [PROD_W-1:0]    rsp_product,
    output logic                 busy,
    output logic [1:0]           grant_id
);

    arb_state_t        state_q, state_d;
    logic [1:0]        last_q, grant_q, pick;
    logic              pick_vld, accept;
    logic [2:0]        cand;
    logic [3:0]        valid_pad, ready_pad, rsp_pad, rsp_ready_pad;
    logic [31:0]       a_pad, b_pad;
    logic [PROD_W-1:0] product_q, core_product;
    logic              core_done;

    // Pad to the 4-requester maximum so indexing is width-exact for any NREQ.
    assign valid_pad     = 4'(req_valid);
    assign rsp_ready_pad = 4'(rsp_ready);
    assign a_pad         = 32'(req_a);
    assign b_pad         = 32'(req_b);

    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_q} + 3'(k);
            if (cand >= 3'(NREQ)) cand = cand - 3'(NREQ);
            if (!pick_vld && valid_pad[cand[1:0]]) begin
                pick_vld = 1'b1;
                pick     = cand[1:0];
            end
        end
    end

    assign accept = (state_q == ST_IDLE) && pick_vld;

    always_comb begin
        ready_pad = '0;
        rsp_pad   = '0;
        if (accept) ready_pad[pick] = 1'b1;
        if (state_q == ST_RESP) rsp_pad[grant_q] = 1'b1;
    end

    assign req_ready   = ready_pad[NREQ-1:0];
    assign rsp_valid   = rsp_pad[NREQ-1:0];
    assign rsp_product = product_q;
    assign busy        = (state_q != ST_IDLE);
    assign grant_id    = grant_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_CALC;
            ST_CALC: if (core_done) state_d = ST_RESP;
            ST_RESP: if (rsp_ready_pad[grant_q]) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q   <= ST_IDLE;
            last_q    <= 2'(NREQ - 1);
            grant_q   <= '0;
            product_q <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                grant_q <= pick;
                last_q  <= pick;
            end
            if (state_q == ST_CALC && core_done) product_q <= core_product;
        end
    end

    mul_seq_core u_core (
        .clk     (pclk),
        .rst_n   (presetn),
        .start   (accept),
        .a       (a_pad[{pick, 3'b000} +: 8]),
        .b       (b_pad[{pick, 3'b000} +: 8]),
        .done    (core_done),
        .product (core_product)
    );

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Directed self-checking bench for mul_share_arbiter with NREQ=2.
module tb_mul_share_arbiter;

    logic        pclk = 1'b0;
    logic        presetn;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready, grant_id;
    logic [15:0] req_a, req_b, rsp_product;
    logic        busy;
    int          errors = 0;
    int          checks = 0;

    always #5 pclk = ~pclk;

    mul_share_arbiter #(.NREQ(2)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .req_valid   (req_valid),
        .req_a       (req_a),
        .req_b       (req_b),
        .req_ready   (req_ready),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_product (rsp_product),
        .busy        (busy),
        .grant_id    (grant_id)
    );

    // Counts cycles from the accept cycle until any rsp_valid is seen; drop clears valids after the accept edge.
    task automatic wait_rsp(input int maxc, input logic [1:0] drop, output int lat, output bit got);
        lat = 0;
        got = 1'b0;
        while (!got && lat < maxc) begin
            @(posedge pclk); #1;
            if (lat == 0) req_valid = req_valid & ~drop;
            lat++;
            @(negedge pclk);
            if (rsp_valid != 2'b00) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        presetn = 1'b0; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 2'b11;
        #3;
        checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL reset_req_ready got %b want 00", req_ready); end
        checks++; if (rsp_valid !== 2'b00) begin errors++; $display("FAIL reset_rsp_valid got %b want 00", rsp_valid); end
        checks++; if (rsp_product !== 16'h0000) begin errors++; $display("FAIL reset_product got %h want 0000", rsp_product); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL reset_grant got %0d want 0", grant_id); end
        @(negedge pclk); presetn = 1'b1;
        @(posedge pclk); #1;
    endtask

    task automatic test_single();
        int lat; bit got;
        req_a[7:0] = 8'd3; req_b[7:0] = 8'd5; req_valid = 2'b01;
        @(negedge pclk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_req_ready got %b want 01", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_T got %b want 0", busy); end
        wait_rsp(50, 2'b01, lat, got);
        checks++; if (got !== 1'b1 || lat != 8) begin errors++; $display("FAIL single_latency got %0d want 8", lat); end
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL single_rsp_valid got %b want 01", rsp_valid); end
        checks++; if (rsp_product !== 16'd15) begin errors++; $display("FAIL single_product got %h want 000f", rsp_product); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_R got %b want 1", busy); end
        @(posedge pclk); #1;
        @(negedge pclk);
        checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00) begin errors++; $display("FAIL single_idle busy %b rsp %b want 0 00", busy, rsp_valid); end
        @(posedge pclk); #1;
    endtask

    task automatic test_signed();
        logic [7:0]  ta[4] = '{8'hF9, 8'h80, 8'h64, 8'h80};
        logic [7:0]  tb[4] = '{8'h06, 8'h80, 8'h00, 8'h7F};
        logic [15:0] tp[4] = '{16'hFFD6, 16'h4000, 16'h0000, 16'hC080};
        int          tl[4] = '{9, 131, 3, 130};
        int lat; bit got;
        for (int i = 0; i < 4; i++) begin
            req_a[7:0] = ta[i]; req_b[7:0] = tb[i]; req_valid = 2'b01;
            wait_rsp(200, 2'b01, lat, got);
            checks++; if (got !== 1'b1 || lat != tl[i]) begin errors++; $display("FAIL signed%0d_latency got %0d want %0d", i, lat, tl[i]); end
            checks++; if (rsp_product !== tp[i]) begin errors++; $display("FAIL signed%0d_product got %h want %h", i, rsp_product, tp[i]); end
            checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL signed%0d_rsp_valid got %b want 01", i, rsp_valid); end
            @(posedge pclk); #1;
        end
    endtask

    task automatic test_backpressure();
        int lat; bit got; bit stable;
        rsp_ready = 2'b10;
        req_a[7:0] = 8'h09; req_b[7:0] = 8'hFD; req_valid = 2'b01;
        wait_rsp(50, 2'b01, lat, got);
        checks++; if (got !== 1'b1 || lat != 6) begin errors++; $display("FAIL bp_latency got %0d want 6", lat); end
        checks++; if (rsp_product !== 16'hFFE5) begin errors++; $display("FAIL bp_product got %h want ffe5", rsp_product); end
        req_a[15:8] = 8'd4; req_b[15:8] = 8'd4; req_valid[1] = 1'b1;
        stable = 1'b1;
        repeat (10) begin
            @(negedge pclk);
            if (rsp_valid !== 2'b01 || rsp_product !== 16'hFFE5 || req_ready !== 2'b00 || busy !== 1'b1) stable = 1'b0;
        end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_hold rsp %b prod %h rdy %b busy %b", rsp_valid, rsp_product, req_ready, busy); end
        @(posedge pclk); #1; rsp_ready = 2'b11;
        @(negedge pclk);
        checks++; if (rsp_valid !== 2'b01) begin errors++; $display("FAIL bp_release_cycle got %b want 01", rsp_valid); end
        @(posedge pclk); #1;
        @(negedge pclk);
        checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_next_ready got %b want 10", req_ready); end
        wait_rsp(50, 2'b10, lat, got);
        checks++; if (got !== 1'b1 || lat != 7) begin errors++; $display("FAIL bp_r1_latency got %0d want 7", lat); end
        checks++; if (rsp_valid !== 2'b10 || rsp_product !== 16'h0010) begin errors++; $display("FAIL bp_r1_rsp got %b %h want 10 0010", rsp_valid, rsp_product); end
        checks++; if (grant_id !== 2'd1) begin errors++; $display("FAIL bp_r1_grant got %0d want 1", grant_id); end
        @(posedge pclk); #1;
    endtask

    task automatic test_reset_mid();
        int lat; bit got;
        req_a[7:0] = 8'd1; req_b[7:0] = 8'd50; req_valid = 2'b01;
        @(posedge pclk); #1; req_valid = 2'b00;
        repeat (19) @(posedge pclk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_busy_before got %b want 1", busy); end
        presetn = 1'b0;
        #1;
        checks++; if (busy !== 1'b0 || rsp_valid !== 2'b00 || req_ready !== 2'b00) begin errors++; $display("FAIL rmid_outputs busy %b rsp %b rdy %b want 0 00 00", busy, rsp_valid, req_ready); end
        checks++; if (rsp_product !== 16'h0000) begin errors++; $display("FAIL rmid_product got %h want 0000", rsp_product); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rmid_grant got %0d want 0", grant_id); end
        @(negedge pclk); presetn = 1'b1;
        @(posedge pclk); #1;
        req_a = {8'd5, 8'hFD}; req_b = {8'd5, 8'd7}; req_valid = 2'b11;
        @(negedge pclk);
        checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL rmid_first_ready got %b want 01", req_ready); end
        wait_rsp(50, 2'b01, lat, got);
        checks++; if (got !== 1'b1 || lat != 10) begin errors++; $display("FAIL rmid_r0_latency got %0d want 10", lat); end
        checks++; if (rsp_valid !== 2'b01 || rsp_product !== 16'hFFEB) begin errors++; $display("FAIL rmid_r0_rsp got %b %h want 01 ffeb", rsp_valid, rsp_product); end
        checks++; if (grant_id !== 2'd0) begin errors++; $display("FAIL rmid_r0_grant got %0d want 0", grant_id); end
        @(posedge pclk); #1;
        wait_rsp(50, 2'b10, lat, got);
        checks++; if (got !== 1'b1 || lat != 8) begin errors++; $display("FAIL rmid_r1_latency got %0d want 8", lat); end
        checks++; if (rsp_valid !== 2'b10 || rsp_product !== 16'h0019) begin errors++; $display("FAIL rmid_r1_rsp got %b %h want 10 0019", rsp_valid, rsp_product); end
        @(posedge pclk); #1;
    endtask

    task automatic test_back_to_back();
        logic [1:0]  exp_v[4] = '{2'b01, 2'b10, 2'b01, 2'b10};
        logic [15:0] exp_p[4] = '{16'h0006, 16'hFFEC, 16'h0006, 16'hFFEC};
        int          exp_l[4] = '{6, 7, 6, 7};
        int lat; bit got;
        req_a = {8'hFB, 8'h02}; req_b = {8'h04, 8'h03}; req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            wait_rsp(50, 2'b00, lat, got);
            if (i == 3) req_valid = 2'b00;
            checks++; if (got !== 1'b1 || lat != exp_l[i]) begin errors++; $display("FAIL b2b%0d_latency got %0d want %0d", i, lat, exp_l[i]); end
            checks++; if (rsp_valid !== exp_v[i]) begin errors++; $display("FAIL b2b%0d_rsp_valid got %b want %b", i, rsp_valid, exp_v[i]); end
            checks++; if (rsp_product !== exp_p[i]) begin errors++; $display("FAIL b2b%0d_product got %h want %h", i, rsp_product, exp_p[i]); end
            checks++; if (grant_id !== 2'(i % 2)) begin errors++; $display("FAIL b2b%0d_grant got %0d want %0d", i, grant_id, i % 2); end
            @(posedge pclk); #1;
        end
        @(negedge pclk);
        checks++; if (busy !== 1'b0 || req_ready !== 2'b00) begin errors++; $display("FAIL b2b_idle busy %b rdy %b want 0 00", busy, req_ready); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
